// File: rtl/hc8_memory_bus_master.sv
// HC8 external asynchronous SRAM bus initiator.
// Sequences setup/strobe/hold timing from registered strobes and owns the data-bus tristate.
module hc8_memory_bus_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic [15:0] mem_address,
  inout  wire  [7:0]  mem_data,
  output logic        mem_nchip_enable,
  output logic        mem_nwrite_enable,
  output logic        mem_nread_enable
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_load;
  logic       accept;

  logic       write_q;
  logic [7:0] wdata_q;
  logic       drive_q;

  logic       write_nxt;
  logic       active_nxt;
  logic       strobe_nxt;
  logic       ce_d;
  logic       we_d;
  logic       re_d;
  logic       drive_d;
  logic       busy_d;
  logic       rsp_d;
  logic       sample_d;

  assign req_ready = nreset && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // State register with per-state down-counter reloaded on every state entry.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= cnt_load;
      end else if (cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = '0;
    unique case (state)
      ST_IDLE:   if (accept)      state_nxt = ST_SETUP;
      ST_SETUP:  if (cnt == '0)   state_nxt = ST_STROBE;
      ST_STROBE: if (cnt == '0)   state_nxt = ST_HOLD;
      ST_HOLD:   if (cnt == '0)   state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
    unique case (state_nxt)
      ST_SETUP:  cnt_load = SETUP_LOAD;
      ST_STROBE: cnt_load = STROBE_LOAD;
      ST_HOLD:   cnt_load = HOLD_LOAD;
      default:   cnt_load = '0;
    endcase
  end

  // Outputs are decoded from the upcoming state and then registered, so the
  // pins change only on clock edges and can never glitch.
  always_comb begin
    write_nxt  = accept ? req_write : write_q;
    active_nxt = (state_nxt != ST_IDLE);
    strobe_nxt = (state_nxt == ST_STROBE);
    ce_d       = !active_nxt;
    we_d       = !(strobe_nxt && write_nxt);
    re_d       = !(strobe_nxt && !write_nxt);
    drive_d    = active_nxt && write_nxt;
    busy_d     = active_nxt;
    rsp_d      = (state == ST_HOLD) && (state_nxt == ST_IDLE);
    sample_d   = (state == ST_STROBE) && (state_nxt == ST_HOLD) && !write_q;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      mem_address       <= '0;
      mem_nchip_enable  <= 1'b1;
      mem_nwrite_enable <= 1'b1;
      mem_nread_enable  <= 1'b1;
      drive_q           <= 1'b0;
      busy              <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
    end else begin
      if (accept) begin
        mem_address <= req_addr;
      end
      mem_nchip_enable  <= ce_d;
      mem_nwrite_enable <= we_d;
      mem_nread_enable  <= re_d;
      drive_q           <= drive_d;
      busy              <= busy_d;
      rsp_valid         <= rsp_d;
      if (sample_d) begin
        rsp_rdata <= mem_data;
      end
    end
  end

  assign mem_data = drive_q ? wdata_q : 'z;

  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!nreset)
    !(!mem_nwrite_enable && !mem_nread_enable));
  a_strobe_needs_ce: assert property (@(posedge clk) disable iff (!nreset)
    (!mem_nwrite_enable || !mem_nread_enable) |-> !mem_nchip_enable);
  a_no_contention: assert property (@(posedge clk) disable iff (!nreset)
    !(drive_q && !mem_nread_enable));

endmodule

// File: tb/tb_hc8_memory_bus_master.sv
// Randomized bench for hc8_memory_bus_master: two instances (default and 3/1/2 timing)
// checked cycle by cycle against a transaction-level timing schedule and byte memory model.
module tb_hc8_memory_bus_master;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;

  logic        rv_a, ready_a, rsp_valid_a, busy_a, ce_a, we_a, re_a;
  logic [7:0]  rdata_a;
  logic [15:0] addr_a;
  tri1  [7:0]  data_a;
  logic        rv_b, ready_b, rsp_valid_b, busy_b, ce_b, we_b, re_b;
  logic [7:0]  rdata_b;
  logic [15:0] addr_b;
  tri1  [7:0]  data_b;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  last_rd = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          s_cyc = 1, t_cyc = 2, h_cyc = 1;

  always #5 clk = ~clk;

  assign rv_a = req_valid && !sel;
  assign rv_b = req_valid && sel;

  hc8_memory_bus_master u_dut_a (
    .clk(clk), .nreset(nreset), .req_valid(rv_a), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .busy(busy_a),
    .mem_address(addr_a), .mem_data(data_a), .mem_nchip_enable(ce_a),
    .mem_nwrite_enable(we_a), .mem_nread_enable(re_a)
  );

  hc8_memory_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) u_dut_b (
    .clk(clk), .nreset(nreset), .req_valid(rv_b), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .busy(busy_b),
    .mem_address(addr_b), .mem_data(data_b), .mem_nchip_enable(ce_b),
    .mem_nwrite_enable(we_b), .mem_nread_enable(re_b)
  );

  // Asynchronous SRAM model; a released bus reads as the pull-up value 8'hFF.
  assign data_a = (!re_a && !ce_a) ? mem[addr_a] : 'z;
  assign data_b = (!re_b && !ce_b) ? mem[addr_b] : 'z;

  always @(posedge clk) begin
    if (!we_a && !ce_a) mem[addr_a] <= data_a;
    if (!we_b && !ce_b) mem[addr_b] <= data_b;
  end

  logic        o_ready, o_rsp, o_busy, o_ce, o_we, o_re;
  logic [7:0]  o_rdata, o_data;
  logic [15:0] o_addr;
  assign o_ready = sel ? ready_b     : ready_a;
  assign o_rsp   = sel ? rsp_valid_b : rsp_valid_a;
  assign o_busy  = sel ? busy_b      : busy_a;
  assign o_ce    = sel ? ce_b        : ce_a;
  assign o_we    = sel ? we_b        : we_a;
  assign o_re    = sel ? re_b        : re_a;
  assign o_rdata = sel ? rdata_b     : rdata_a;
  assign o_data  = sel ? data_b      : data_a;
  assign o_addr  = sel ? addr_b      : addr_a;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic select_dut(input logic which);
    sel = which;
    if (which) begin
      s_cyc = 3; t_cyc = 1; h_cyc = 2;
    end else begin
      s_cyc = 1; t_cyc = 2; h_cyc = 1;
    end
  endtask

  task automatic check_idle_reset(input string tag, input logic ready_exp);
    check_eq({tag, "_ce"},    32'(o_ce), 32'd1);
    check_eq({tag, "_we"},    32'(o_we), 32'd1);
    check_eq({tag, "_re"},    32'(o_re), 32'd1);
    check_eq({tag, "_data"},  32'(o_data), 32'hFF);
    check_eq({tag, "_rsp"},   32'(o_rsp), 32'd0);
    check_eq({tag, "_busy"},  32'(o_busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(o_ready), 32'(ready_exp));
  endtask

  // One single-beat transaction; called and returning at a falling edge.
  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [7:0] d, input logic keep);
    int lat;
    int waited;
    logic strobe;
    logic act;
    logic [7:0] data_exp;
    lat = s_cyc + t_cyc + h_cyc + 1;
    waited = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("accept_wait", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    if (wr) ref_mem[a] = d;
    else    last_rd = ref_mem[a];
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      strobe = (k > s_cyc) && (k <= s_cyc + t_cyc);
      act    = (k <= s_cyc + t_cyc + h_cyc);
      if (wr && act)          data_exp = d;
      else if (!wr && strobe) data_exp = ref_mem[a];
      else                    data_exp = 8'hFF;
      check_eq("ce",    32'(o_ce), 32'(!act));
      check_eq("we",    32'(o_we), 32'(!(wr && strobe)));
      check_eq("re",    32'(o_re), 32'(!(!wr && strobe)));
      check_eq("addr",  32'(o_addr), 32'(a));
      check_eq("data",  32'(o_data), 32'(data_exp));
      check_eq("busy",  32'(o_busy), 32'(k < lat));
      check_eq("rsp",   32'(o_rsp), 32'(k == lat));
      check_eq("ready", 32'(o_ready), 32'(k == lat));
      if (k == lat) check_eq("rdata", 32'(o_rdata), 32'(last_rd));
    end
  endtask

  task automatic random_txns(input int count);
    logic [15:0] a;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      run_txn(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'hFFFF]     = 8'h3C;
    ref_mem[16'hFFFF] = 8'h3C;
    select_dut(1'b0);

    repeat (3) begin
      @(negedge clk);
      check_idle_reset("rst", 1'b0);
      check_eq("rst_addr",  32'(o_addr), 32'd0);
      check_eq("rst_rdata", 32'(o_rdata), 32'd0);
    end
    @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    check_idle_reset("post_rst", 1'b1);

    run_txn(1'b1, 16'h1234, 8'hA5, 1'b0);
    check_eq("mem_1234", 32'(mem[16'h1234]), 32'hA5);
    run_txn(1'b0, 16'hFFFF, 8'h00, 1'b0);
    run_txn(1'b1, 16'h5555, 8'h96, 1'b0);
    run_txn(1'b0, 16'h1234, 8'h00, 1'b0);
    run_txn(1'b1, 16'h0000, 8'h11, 1'b1);
    run_txn(1'b0, 16'h0000, 8'h00, 1'b0);
    random_txns(25);

    // Abort a write in its strobe cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0042; req_wdata = 8'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_we_low", 32'(o_we), 32'd0);
    nreset = 1'b0;
    @(negedge clk);
    check_idle_reset("abort", 1'b0);
    @(posedge clk);
    #1 nreset = 1'b1;
    last_rd = '0;
    ref_mem[16'h0042] = mem[16'h0042];
    repeat (6) begin
      @(negedge clk);
      check_idle_reset("abort_after", 1'b1);
    end

    select_dut(1'b1);
    run_txn(1'b1, 16'h0042, 8'h5A, 1'b0);
    run_txn(1'b0, 16'h0042, 8'h00, 1'b0);
    run_txn(1'b1, 16'hFFFF, 8'hC3, 1'b1);
    run_txn(1'b0, 16'hFFFF, 8'h00, 1'b0);
    random_txns(15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
